// File: rtl/apb_completer_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ APB requesters onto a single APB completer.
// Define APB_ARB_TIMEOUT_EN to add an ACCESS wait limit with an error response.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_completer_arbiter #(
  parameter int unsigned ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = `DATA_WIDTH,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            pclk,
  input  logic                            preset_n,
  input  logic [NUM_REQ-1:0]              s_psel,
  input  logic [NUM_REQ-1:0]              s_penable,
  input  logic [NUM_REQ-1:0]              s_pwrite,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_paddr,
  input  logic [NUM_REQ*3-1:0]            s_pprot,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_pwdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_pstrb,
  output logic [NUM_REQ-1:0]              s_pready,
  output logic [NUM_REQ*DATA_WIDTH-1:0]   s_prdata,
  output logic [NUM_REQ-1:0]              s_pslverr,
  output logic                            m_psel,
  output logic                            m_penable,
  output logic                            m_pwrite,
  output logic [ADDR_WIDTH-1:0]           m_paddr,
  output logic [2:0]                      m_pprot,
  output logic [DATA_WIDTH-1:0]           m_pwdata,
  output logic [DATA_WIDTH/8-1:0]         m_pstrb,
  input  logic                            m_pready,
  input  logic                            m_pslverr,
  input  logic [DATA_WIDTH-1:0]           m_prdata,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state, state_d;
  logic [GW-1:0]           winner;
  logic                    any_req;
  int unsigned             rr_idx;
  logic                    timeout;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [2:0]              pprot_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [SW-1:0]           pstrb_q;
  logic                    cfg_unused;

  // The arbiter keys on psel alone; penable is carried only for port compatibility.
  assign cfg_unused = ^{s_penable, TIMEOUT_CYCLES};

  // Search starts one past the last grant and ends on the last grant itself.
  always_comb begin
    winner  = grant_id;
    any_req = 1'b0;
    rr_idx  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_idx = 32'(grant_id) + i;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!any_req && s_psel[rr_idx]) begin
        any_req = 1'b1;
        winner  = GW'(rr_idx);
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  assign timeout = (state == ACCESS) && !m_pready && (wait_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !m_pready && !timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state    <= IDLE;
      grant_id <= GW'(NUM_REQ - 1);
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && any_req) begin
        grant_id <= winner;
        pwrite_q <= s_pwrite[winner];
        paddr_q  <= s_paddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        pprot_q  <= s_pprot[winner*3 +: 3];
        pwdata_q <= s_pwdata[winner*DATA_WIDTH +: DATA_WIDTH];
        pstrb_q  <= s_pstrb[winner*SW +: SW];
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (m_pready || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_psel    = (state != IDLE);
    m_penable = (state == ACCESS);
    m_pwrite  = 1'b0;
    m_paddr   = '0;
    m_pprot   = '0;
    m_pwdata  = '0;
    m_pstrb   = '0;
    s_pready  = '0;
    s_prdata  = '0;
    s_pslverr = '0;
    if (state != IDLE) begin
      m_pwrite = pwrite_q;
      m_paddr  = paddr_q;
      m_pprot  = pprot_q;
      m_pwdata = pwdata_q;
      m_pstrb  = pstrb_q;
    end
    if (state == ACCESS) begin
      if (timeout) begin
        s_pready[grant_id]  = 1'b1;
        s_pslverr[grant_id] = 1'b1;
      end else begin
        s_pready[grant_id]                           = m_pready;
        s_pslverr[grant_id]                          = m_pslverr;
        s_prdata[grant_id*DATA_WIDTH +: DATA_WIDTH]  = m_prdata;
      end
    end
  end

endmodule

// File: doc/apb_completer_arbiter.md
APB_COMPLETER_ARBITER -- requirements
Module: apb_completer_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, `ADDR_WIDTH, address width
- DATA_WIDTH, `DATA_WIDTH, data width
- NUM_REQ, 4, requester ports (2..8)
- TIMEOUT_CYCLES, 16, ACCESS wait limit (used only with APB_ARB_TIMEOUT_EN)

REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.

REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- pclk  in  1  clock
- preset_n  in  1  async active-low reset
- s_psel  in  NUM_REQ  per-requester select
- s_penable  in  NUM_REQ  per-requester enable
- s_pwrite  in  NUM_REQ  per-requester direction
- s_paddr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- s_pprot  in  NUM_REQ*3  packed protection
- s_pwdata  in  NUM_REQ*DATA_WIDTH  packed write data
- s_pstrb  in  NUM_REQ*DATA_WIDTH/8  packed strobes
- s_pready  out  NUM_REQ  per-requester ready
- s_prdata  out  NUM_REQ*DATA_WIDTH  packed read data
- s_pslverr  out  NUM_REQ  per-requester error
- m_psel, m_penable, m_pwrite  out  1 each  completer control
- m_paddr  out  ADDR_WIDTH; m_pprot  out  3; m_pwdata  out  DATA_WIDTH; m_pstrb  out  DATA_WIDTH/8
- m_pready, m_pslverr  in  1 each; m_prdata  in  DATA_WIDTH  completer response
- grant_id  out  $clog2(NUM_REQ)  index of the current or last-granted requester

Function
REQ-004 The FSM SHALL have states IDLE, SETUP and ACCESS.

REQ-005 IDLE: when any s_psel bit is high, the block SHALL grant round-robin, searching from the index after grant_id and wrapping at NUM_REQ-1 to 0.
- It SHALL register the winner's pwrite, paddr, pprot, pwdata and pstrb.
- It SHALL go to SETUP.

REQ-006 SETUP SHALL drive m_psel=1 and m_penable=0, then go unconditionally to ACCESS.

REQ-007 ACCESS SHALL drive m_psel=1 and m_penable=1.
- While m_pready=0 it SHALL stay in ACCESS.
- When m_pready=1 it SHALL go to IDLE.

REQ-008 s_pready[grant_id] SHALL equal m_pready combinationally in ACCESS only; all other s_pready bits SHALL be 0.

REQ-009 s_prdata and s_pslverr for grant_id SHALL follow m_prdata and m_pslverr in ACCESS; all other slices SHALL be 0.

REQ-010 m_* address, control and data outputs SHALL come from registered values and SHALL be stable from SETUP through the end of ACCESS, even if the requester changes its inputs.

REQ-011 One idle cycle SHALL separate back-to-back transfers.
- Minimum transfer: 3 cycles from s_psel to s_pready with a zero-wait completer.

REQ-012 Requesters that are not granted SHALL see s_pready=0 and SHALL wait; no request SHALL be dropped.

REQ-013 A requester that deasserts s_psel after being granted SHALL NOT abort the completer transfer; the transfer SHALL finish normally.

REQ-014 In IDLE, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb and m_pprot SHALL be 0.

Reset
REQ-015 While preset_n=0 the block SHALL immediately (asynchronously) force:
- state to IDLE;
- m_psel, m_penable and all registered m_* fields to 0;
- s_pready, s_prdata and s_pslverr to 0;
- grant_id to NUM_REQ-1, so requester 0 wins first.

REQ-016 Reset asserted mid-transfer SHALL abandon the transfer with no response to the requester.

Configuration
REQ-017 Macro APB_ARB_TIMEOUT_EN:
- Defined: a counter SHALL count ACCESS cycles with m_pready=0. When the count reaches TIMEOUT_CYCLES, the block SHALL drive s_pready[grant_id]=1, s_pslverr[grant_id]=1 and s_prdata=0 for one cycle, then go to IDLE with m_psel dropped. The counter SHALL clear on entry to ACCESS and on reset.
- Undefined: ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-018 Requester 0 writes 0x10 with 0xA5A5A5A5 to a zero-wait completer -> m_psel high 2 cycles, m_penable high 1 cycle, s_pready[0] pulses on cycle 3, m_paddr=0x10.

REQ-019 Requesters 0 and 2 assert simultaneously after reset, then again -> grant order 0, 2, 0, 2; each waiting requester's s_pready stays 0 until served.

REQ-020 Requester 1 reads from a completer with 3 wait states and prdata=0xFFFFFFFF -> ACCESS lasts 4 cycles; s_prdata slice 1=0xFFFFFFFF with s_pready[1]; other slices 0.

REQ-021 preset_n dropped during ACCESS -> m_psel, m_penable and s_pready become 0 in the same cycle; after release, requester 0 is granted first.

REQ-022 With APB_ARB_TIMEOUT_EN defined and m_pready tied 0 -> after 16 ACCESS cycles s_pready[g]=1, s_pslverr[g]=1, then IDLE. Without the macro -> ACCESS persists for more than 100 cycles.
